inst_fetch_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 13 +
 rtl/inst_fetch_ctrl_if.sv | 25 ++
 rtl/next_pc_calc.sv | 27 ++
 rtl/inst_fetch_ctrl.sv | 100 ++++++++++
 tb/tb_inst_fetch_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, next-PC select and opcodes
// that the decode stage reuses.
package cpu_pkg;
  localparam int          INST_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;
  typedef enum logic [1:0] {NPC_SEQ, NPC_BR, NPC_JMP} npc_sel_e;
endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch <-> ROM/decode bus. The master side is the fetch sequencer.
interface inst_fetch_ctrl_if;
  import cpu_pkg::*;
  logic [31:0]       Addr;
  logic [INST_W-1:0] Inst;
  logic [INST_W-1:0] Inst_Out;
  logic [31:0]       PC_Out;
  logic              Valid;
  logic              Ready;
  logic              Br_Taken;
  logic [15:0]       Br_Imm;
  logic              J_Taken;
  logic [25:0]       J_Idx;
  logic              Halted;
  logic [31:0]       Fetch_Count;

  modport master (
    output Addr, Inst_Out, PC_Out, Valid, Halted, Fetch_Count,
    input  Inst, Ready, Br_Taken, Br_Imm, J_Taken, J_Idx
  );
  modport slave (
    input  Addr, Inst_Out, PC_Out, Valid, Halted, Fetch_Count,
    output Inst, Ready, Br_Taken, Br_Imm, J_Taken, J_Idx
  );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC mux: sequential, branch or jump target.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_out,
  input  logic [15:0] i_br_imm,
  input  logic [25:0] i_j_idx,
  input  npc_sel_e    i_sel,
  output logic [31:0] o_next_pc
);
  logic [31:0] w_pc_out_p4;
  logic [31:0] w_br_off;

  // Redirect targets are relative to the instruction sitting in IR.
  assign w_pc_out_p4 = i_pc_out + PC_INC;
  assign w_br_off    = {{14{i_br_imm[15]}}, i_br_imm, 2'b00};

  always_comb begin
    o_next_pc = i_pc + PC_INC;
    case (i_sel)
      NPC_BR:  o_next_pc = w_pc_out_p4 + w_br_off;
      NPC_JMP: o_next_pc = {w_pc_out_p4[31:28], i_j_idx, 2'b00};
      default: o_next_pc = i_pc + PC_INC;
    endcase
  end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, registers ROM data into IR, applies
// redirects with one flush bubble and halts outside the ROM window.
module inst_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 32
) (
  input logic                Clk,
  input logic                Reset,
  inst_fetch_ctrl_if.master  bus
);
  localparam logic [31:0] ROM_LIM = 32'(ROM_WORDS);

  state_e            r_state, w_state_nxt;
  logic [31:0]       r_pc, r_pc_out, r_fetch_cnt;
  logic [INST_W-1:0] r_ir;
  logic              r_valid, r_halted;

  logic        w_acc, w_adv, w_redir, w_oor;
  logic        w_load, w_pc_upd, w_clr_valid, w_cnt_inc;
  npc_sel_e    w_sel;
  logic [31:0] w_next_pc;

  assign w_acc   = r_valid & bus.Ready;
  assign w_adv   = bus.Ready | ~r_valid;
  assign w_redir = w_acc & (bus.J_Taken | bus.Br_Taken);
  assign w_oor   = {2'b00, r_pc[31:2]} >= ROM_LIM;

  next_pc_calc u_npc (
    .i_pc      (r_pc),
    .i_pc_out  (r_pc_out),
    .i_br_imm  (bus.Br_Imm),
    .i_j_idx   (bus.J_Idx),
    .i_sel     (w_sel),
    .o_next_pc (w_next_pc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pc_upd    = 1'b0;
    w_clr_valid = 1'b0;
    w_cnt_inc   = 1'b0;
    w_sel       = NPC_SEQ;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_cnt_inc = w_acc;
        if (w_redir) begin
          // Redirect flushes the wrong-path IR; target is fetched next cycle.
          w_sel       = bus.J_Taken ? NPC_JMP : NPC_BR;
          w_pc_upd    = 1'b1;
          w_clr_valid = 1'b1;
        end else if (w_adv) begin
          if (w_oor) begin
            w_clr_valid = 1'b1;
            w_state_nxt = ST_HALT;
          end else begin
            w_load   = 1'b1;
            w_pc_upd = 1'b1;
          end
        end
      end
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_pc_out    <= '0;
      r_valid     <= 1'b0;
      r_halted    <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_halted <= (w_state_nxt == ST_HALT);
      if (w_pc_upd) r_pc <= w_next_pc;
      if (w_load) begin
        r_ir     <= bus.Inst;
        r_pc_out <= r_pc;
        r_valid  <= 1'b1;
      end else if (w_clr_valid) begin
        r_valid <= 1'b0;
      end
      if (w_cnt_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign bus.Addr        = r_pc;
  assign bus.Inst_Out    = r_ir;
  assign bus.PC_Out      = r_pc_out;
  assign bus.Valid       = r_valid;
  assign bus.Halted      = r_halted;
  assign bus.Fetch_Count = r_fetch_cnt;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: boot, jump, branches, stall, halt, reset.
module tb_inst_fetch_ctrl;
  logic Clk = 1'b0;
  logic Reset;
  int   n_chk = 0;
  int   n_err = 0;

  inst_fetch_ctrl_if bus();

  inst_fetch_ctrl #(.RESET_PC(32'h0), .ROM_WORDS(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // ROM word i holds 0xA500_0000 | i; outside the window reads 0xDEADBEEF.
  function automatic logic [31:0] rom_rd(input logic [31:0] a);
    if (a[31:2] < 30'd32) return 32'hA500_0000 | {2'b00, a[31:2]};
    return 32'hDEAD_BEEF;
  endfunction
  assign bus.Inst = rom_rd(bus.Addr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    bus.Ready    = 1'b1;
    bus.Br_Taken = 1'b0;
    bus.Br_Imm   = '0;
    bus.J_Taken  = 1'b0;
    bus.J_Idx    = '0;
    Reset        = 1'b1;
    step();
    chk("rst_valid", {31'b0, bus.Valid}, 32'd0);
    chk("rst_pcout", bus.PC_Out, 32'h0);
    chk("rst_ir",    bus.Inst_Out, 32'h0);
    chk("rst_halt",  {31'b0, bus.Halted}, 32'd0);
    chk("rst_cnt",   bus.Fetch_Count, 32'd0);
    step();
    Reset = 1'b0;

    // Boot: cycle 0 in BOOT, first IR load two edges later.
    chk("boot_addr",  bus.Addr, 32'h0);
    chk("boot_valid", {31'b0, bus.Valid}, 32'd0);
    step();
    chk("run0_valid", {31'b0, bus.Valid}, 32'd0);
    step();
    chk("c2_valid", {31'b0, bus.Valid}, 32'd1);
    chk("c2_pcout", bus.PC_Out, 32'h0);
    chk("c2_ir",    bus.Inst_Out, 32'hA500_0000);

    // Sequential stream up to 0x18.
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("seq_pcout", bus.PC_Out, 32'(i * 4));
      chk("seq_ir",    bus.Inst_Out, 32'hA500_0000 | 32'(i));
    end
    chk("seq_cnt", bus.Fetch_Count, 32'd6);

    // Jump from 0x18 to 0x30.
    bus.J_Taken = 1'b1;
    bus.J_Idx   = 26'h0C;
    step();
    bus.J_Taken = 1'b0;
    chk("j_cnt",   bus.Fetch_Count, 32'd7);
    chk("j_addr",  bus.Addr, 32'h30);
    chk("j_valid", {31'b0, bus.Valid}, 32'd0);
    step();
    chk("j_pcout", bus.PC_Out, 32'h30);
    chk("j_ir",    bus.Inst_Out, 32'hA500_000C);

    // Not-taken branch, then taken +4 from 0x34 -> 0x48.
    step();
    chk("nt_pcout", bus.PC_Out, 32'h34);
    bus.Br_Taken = 1'b1;
    bus.Br_Imm   = 16'd4;
    step();
    bus.Br_Taken = 1'b0;
    chk("br_addr",  bus.Addr, 32'h48);
    chk("br_valid", {31'b0, bus.Valid}, 32'd0);
    step();
    chk("br_pcout", bus.PC_Out, 32'h48);
    chk("br_valid2", {31'b0, bus.Valid}, 32'd1);

    // Branch to self with -1.
    bus.Br_Taken = 1'b1;
    bus.Br_Imm   = 16'hFFFF;
    step();
    bus.Br_Taken = 1'b0;
    chk("self_addr",  bus.Addr, 32'h48);
    chk("self_valid", {31'b0, bus.Valid}, 32'd0);
    step();
    chk("self_pcout", bus.PC_Out, 32'h48);
    chk("self_cnt",   bus.Fetch_Count, 32'd10);

    // Stall at 0x10 with a branch pulse that must be ignored.
    do_reset();
    step();
    step();
    for (int i = 0; i < 4; i++) step();
    chk("pre_stall_pcout", bus.PC_Out, 32'h10);
    chk("pre_stall_cnt",   bus.Fetch_Count, 32'd4);
    bus.Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.Br_Taken = (i == 1);
      bus.Br_Imm   = 16'd8;
      step();
      chk("stall_pcout", bus.PC_Out, 32'h10);
      chk("stall_ir",    bus.Inst_Out, 32'hA500_0004);
      chk("stall_addr",  bus.Addr, 32'h14);
      chk("stall_cnt",   bus.Fetch_Count, 32'd4);
    end
    bus.Br_Taken = 1'b0;
    bus.Ready    = 1'b1;
    step();
    chk("resume_pcout", bus.PC_Out, 32'h14);
    chk("resume_cnt",   bus.Fetch_Count, 32'd5);

    // Run off the end of the ROM window.
    for (int i = 0; i < 26; i++) step();
    chk("last_pcout", bus.PC_Out, 32'h7C);
    chk("last_valid", {31'b0, bus.Valid}, 32'd1);
    chk("last_halt",  {31'b0, bus.Halted}, 32'd0);
    chk("last_addr",  bus.Addr, 32'h80);
    chk("last_cnt",   bus.Fetch_Count, 32'd31);
    step();
    chk("halt_valid", {31'b0, bus.Valid}, 32'd0);
    chk("halt_flag",  {31'b0, bus.Halted}, 32'd1);
    chk("halt_cnt",   bus.Fetch_Count, 32'd32);
    step();
    step();
    chk("halt_addr",  bus.Addr, 32'h80);
    chk("halt_hold",  {31'b0, bus.Halted}, 32'd1);

    // Asynchronous reset in the middle of HALT.
    #2;
    Reset = 1'b1;
    #1;
    chk("hrst_addr",  bus.Addr, 32'h0);
    chk("hrst_valid", {31'b0, bus.Valid}, 32'd0);
    chk("hrst_halt",  {31'b0, bus.Halted}, 32'd0);
    chk("hrst_cnt",   bus.Fetch_Count, 32'd0);
    chk("hrst_pcout", bus.PC_Out, 32'h0);
    chk("hrst_ir",    bus.Inst_Out, 32'h0);
    step();
    Reset = 1'b0;
    step();
    step();
    chk("reboot_pcout", bus.PC_Out, 32'h0);
    chk("reboot_valid", {31'b0, bus.Valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
